// File: rtl/sram_arb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_ctrl_pkg
// Shared definitions for the two-port SRAM arbiter/controller:
//   - FSM state encoding
//   - request operation classification
//   - SRAM word-address width derivation
//   - byte-strobed merge used by the read-modify-write path
// ---------------------------------------------------------------------------
package sram_arb_ctrl_pkg;

  localparam int unsigned DEPTH_DEFAULT  = 65536;
  localparam int unsigned ADDR_W_DEFAULT = 32;
  localparam int unsigned WORD_BYTES     = 4;

  // Word-address width for an SRAM of depth_bytes bytes of 32-bit words.
  function automatic int unsigned aw_of(input int unsigned depth_bytes);
    return $clog2(depth_bytes / WORD_BYTES);
  endfunction

  localparam int unsigned AW_DEFAULT = aw_of(DEPTH_DEFAULT);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WR_FULL = 2'd1,
    OP_WR_NOP  = 2'd2,
    OP_WR_PART = 2'd3
  } op_e;

  // Classify a granted request. A write with no strobes touches nothing
  // and is acknowledged like a full write; any other partial strobe needs
  // the old word first.
  function automatic op_e classify(input logic we, input logic [3:0] strb);
    op_e op;
    if (!we) begin
      op = OP_READ;
    end else if (strb == 4'hF) begin
      op = OP_WR_FULL;
    end else if (strb == 4'h0) begin
      op = OP_WR_NOP;
    end else begin
      op = OP_WR_PART;
    end
    return op;
  endfunction

  // Byte merge: strobed bytes come from new_w, the rest from old_w.
  function automatic logic [31:0] merge_bytes(input logic [3:0]  strb,
                                              input logic [31:0] new_w,
                                              input logic [31:0] old_w);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        m[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// ---------------------------------------------------------------------------
// sram_rr_arb2
// Two-requester round-robin arbiter. Grant is combinational from the
// requests; the priority pointer is registered and flips to the other
// requester after every grant, so it only moves when a grant happens.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous reset, active low (pointer -> requester 0)
//   req_i    in   [1:0] request vector
//   en_i     in   grants allowed this cycle
//   gnt_o    out  [1:0] one-hot (or zero) grant
// ---------------------------------------------------------------------------
module sram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // ptr_q = index of the requester that wins the next conflict.
  logic ptr_q;
  logic ptr_d;
  logic [1:0] gnt;

  always_comb begin
    gnt = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt;

endmodule

// File: rtl/sram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// sram_arb_ctrl
// Shares one single-write/single-read 32-bit SRAM (1-cycle registered read
// data, no byte enables) between an instruction-fetch port (p0) and a
// load/store port (p1). One request is granted per cycle with round-robin
// priority; partial writes are done as read-modify-write.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | arbitrating; reads / full writes / null writes complete in 1
//   ST_RMW_WR | old word is on sram_rdata; write merged word, block grants
//
// Ports:
//   clk, rst_n                     clock / synchronous active-low reset
//   pN_req_valid/ready             request handshake (ready is comb on valid)
//   pN_req_addr/we/wstrb/wdata     request payload, byte address
//   pN_resp_valid/rdata            one-cycle response pulse, rdata 0 on acks
//   sram_wen/waddr/wdata           SRAM write port (word address)
//   sram_ren/raddr, sram_rdata     SRAM read port, data valid cycle after ren
// ---------------------------------------------------------------------------
module sram_arb_ctrl
  import sram_arb_ctrl_pkg::*;
#(
  parameter  int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter  int unsigned ADDR_W = ADDR_W_DEFAULT,
  localparam int unsigned AW     = aw_of(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic              p0_req_we,
  input  logic [3:0]        p0_req_wstrb,
  input  logic [31:0]       p0_req_wdata,
  output logic              p0_resp_valid,
  output logic [31:0]       p0_resp_rdata,

  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic              p1_req_we,
  input  logic [3:0]        p1_req_wstrb,
  input  logic [31:0]       p1_req_wdata,
  output logic              p1_resp_valid,
  output logic [31:0]       p1_resp_rdata,

  output logic              sram_wen,
  output logic [AW-1:0]     sram_waddr,
  output logic [31:0]       sram_wdata,
  output logic              sram_ren,
  output logic [AW-1:0]     sram_raddr,
  input  logic [31:0]       sram_rdata
);

  state_e        state_q;
  logic [1:0]    resp_v_q;
  logic          resp_rd_q;
  logic          rmw_port_q;
  logic [AW-1:0] rmw_idx_q;
  logic [3:0]    rmw_strb_q;
  logic [31:0]   rmw_wdata_q;

  logic [1:0]    gnt;
  logic          arb_en;
  logic          sel;
  logic          sel_we;
  logic [3:0]    sel_strb;
  logic [31:0]   sel_wdata;
  logic [AW-1:0] sel_idx;
  op_e           sel_op;

  // Byte-offset and above-SRAM address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{p0_req_addr[ADDR_W-1:AW+2], p0_req_addr[1:0],
                              p1_req_addr[ADDR_W-1:AW+2], p1_req_addr[1:0]};

  // Grants only in IDLE; gating with rst_n keeps a reset cycle free of any
  // SRAM access or handshake, including the abandoned RMW write.
  assign arb_en = (state_q == ST_IDLE) && rst_n;

  sram_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({p1_req_valid, p0_req_valid}),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign p0_req_ready = gnt[0];
  assign p1_req_ready = gnt[1];

  assign sel       = gnt[1];
  assign sel_we    = sel ? p1_req_we    : p0_req_we;
  assign sel_strb  = sel ? p1_req_wstrb : p0_req_wstrb;
  assign sel_wdata = sel ? p1_req_wdata : p0_req_wdata;
  assign sel_idx   = sel ? p1_req_addr[AW+1:2] : p0_req_addr[AW+1:2];
  assign sel_op    = classify(sel_we, sel_strb);

  // SRAM command: driven straight from the grant so a read launched in
  // cycle T returns data in T+1 alongside the response pulse.
  always_comb begin
    sram_wen   = 1'b0;
    sram_waddr = '0;
    sram_wdata = '0;
    sram_ren   = 1'b0;
    sram_raddr = '0;
    if (rst_n) begin
      if (state_q == ST_RMW_WR) begin
        sram_wen   = 1'b1;
        sram_waddr = rmw_idx_q;
        sram_wdata = merge_bytes(rmw_strb_q, rmw_wdata_q, sram_rdata);
      end else if (|gnt) begin
        unique case (sel_op)
          OP_READ, OP_WR_PART: begin
            sram_ren   = 1'b1;
            sram_raddr = sel_idx;
          end
          OP_WR_FULL: begin
            sram_wen   = 1'b1;
            sram_waddr = sel_idx;
            sram_wdata = sel_wdata;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      resp_v_q    <= 2'b00;
      resp_rd_q   <= 1'b0;
      rmw_port_q  <= 1'b0;
      rmw_idx_q   <= '0;
      rmw_strb_q  <= '0;
      rmw_wdata_q <= '0;
    end else begin
      resp_v_q  <= 2'b00;
      resp_rd_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            unique case (sel_op)
              OP_READ: begin
                resp_v_q  <= gnt;
                resp_rd_q <= 1'b1;
              end
              OP_WR_FULL, OP_WR_NOP: begin
                resp_v_q <= gnt;
              end
              OP_WR_PART: begin
                rmw_port_q  <= sel;
                rmw_idx_q   <= sel_idx;
                rmw_strb_q  <= sel_strb;
                rmw_wdata_q <= sel_wdata;
                state_q     <= ST_RMW_WR;
              end
              default: ;
            endcase
          end
        end
        ST_RMW_WR: begin
          resp_v_q[rmw_port_q] <= 1'b1;
          state_q              <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read data passes straight from the SRAM register; acks and idle
  // cycles present zero.
  assign p0_resp_valid = resp_v_q[0];
  assign p1_resp_valid = resp_v_q[1];
  assign p0_resp_rdata = (resp_v_q[0] && resp_rd_q) ? sram_rdata : 32'h0;
  assign p1_resp_rdata = (resp_v_q[1] && resp_rd_q) ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
module tb_sram_arb_ctrl;

  localparam int AW = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_resp_valid;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_resp_rdata;
  logic [3:0]  p0_req_wstrb;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_resp_valid;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_resp_rdata;
  logic [3:0]  p1_req_wstrb;
  logic        sram_wen, sram_ren;
  logic [AW-1:0] sram_waddr, sram_raddr;
  logic [31:0] sram_wdata, sram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_arb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_addr(p0_req_addr), .p0_req_we(p0_req_we),
    .p0_req_wstrb(p0_req_wstrb), .p0_req_wdata(p0_req_wdata),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_addr(p1_req_addr), .p1_req_we(p1_req_we),
    .p1_req_wstrb(p1_req_wstrb), .p1_req_wdata(p1_req_wdata),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
    .sram_wen(sram_wen), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .sram_ren(sram_ren), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM: registered read, plus a preload path for the bench.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (sram_wen) mem[sram_waddr] <= sram_wdata;
    if (sram_ren) sram_rdata <= mem[sram_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_en = 1'b1; pl_addr = idx[AW-1:0]; pl_data = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic v0, input logic v1, input logic we0, input logic we1,
                       input logic [3:0] s0, input logic [3:0] s1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    p0_req_valid = v0; p0_req_we = we0; p0_req_wstrb = s0; p0_req_addr = a0; p0_req_wdata = d0;
    p1_req_valid = v1; p1_req_we = we1; p1_req_wstrb = s1; p1_req_addr = a1; p1_req_wdata = d1;
  endtask

  typedef struct {
    logic v0, v1, we0, we1;
    logic [3:0] s0, s1;
    logic [31:0] a0, a1, d0, d1;
    logic rdy0, rdy1, ren;
    logic [13:0] raddr;
    logic wen;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic rv0, rv1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t tbl [15];

  // Reference model state for the random phase.
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          prefer;
  bit          busy;
  int          busy_idx;
  logic [31:0] busy_val;
  bit          pend_v;
  int          pend_p, pend_due;
  logic [31:0] pend_d;

  initial begin
    //           v0 v1 we0 we1 s0 s1 a0            a1            d0            d1
    //           rdy0 rdy1 ren raddr wen waddr wdata  rv0 rv1 rd0 rd1
    tbl[0]  = '{1,0,0,0,4'h0,4'h0,32'h0001_0010,32'h0,32'h0,32'h0,
                1,0,1,14'd4,0,14'd0,32'h0, 0,0,32'h0,32'h0};
    tbl[1]  = '{1,1,0,0,4'h0,4'h0,32'h14,32'h10,32'h0,32'h0,
                0,1,1,14'd4,0,14'd0,32'h0, 1,0,32'hDEADBEEF,32'h0};
    tbl[2]  = '{1,1,0,0,4'h0,4'h0,32'h14,32'h10,32'h0,32'h0,
                1,0,1,14'd5,0,14'd0,32'h0, 0,1,32'h0,32'hDEADBEEF};
    tbl[3]  = '{1,1,0,0,4'h0,4'h0,32'h14,32'h10,32'h0,32'h0,
                0,1,1,14'd4,0,14'd0,32'h0, 1,0,32'h01020304,32'h0};
    tbl[4]  = '{1,1,0,0,4'h0,4'h0,32'h14,32'h10,32'h0,32'h0,
                1,0,1,14'd5,0,14'd0,32'h0, 0,1,32'h0,32'hDEADBEEF};
    tbl[5]  = '{0,0,0,0,4'h0,4'h0,32'h0,32'h0,32'h0,32'h0,
                0,0,0,14'd0,0,14'd0,32'h0, 1,0,32'h01020304,32'h0};
    tbl[6]  = '{0,1,0,1,4'h0,4'hF,32'h0,32'h20,32'h0,32'h11223344,
                0,1,0,14'd0,1,14'd8,32'h11223344, 0,0,32'h0,32'h0};
    tbl[7]  = '{1,0,0,0,4'h0,4'h0,32'h23,32'h0,32'h0,32'h0,
                1,0,1,14'd8,0,14'd0,32'h0, 0,1,32'h0,32'h0};
    tbl[8]  = '{0,1,0,1,4'h0,4'h5,32'h0,32'h20,32'h0,32'hAABBCCDD,
                0,1,1,14'd8,0,14'd0,32'h0, 1,0,32'h11223344,32'h0};
    tbl[9]  = '{1,1,0,0,4'h0,4'h0,32'h20,32'h14,32'h0,32'h0,
                0,0,0,14'd0,1,14'd8,32'h11BB33DD, 0,0,32'h0,32'h0};
    tbl[10] = '{1,1,0,0,4'h0,4'h0,32'h20,32'h14,32'h0,32'h0,
                1,0,1,14'd8,0,14'd0,32'h0, 0,1,32'h0,32'h0};
    tbl[11] = '{0,1,0,0,4'h0,4'h0,32'h0,32'hFFFF_0014,32'h0,32'h0,
                0,1,1,14'd5,0,14'd0,32'h0, 1,0,32'h11BB33DD,32'h0};
    tbl[12] = '{1,0,1,0,4'h0,4'h0,32'h10,32'h0,32'hFFFFFFFF,32'h0,
                1,0,0,14'd0,0,14'd0,32'h0, 0,1,32'h0,32'h01020304};
    tbl[13] = '{0,0,0,0,4'h0,4'h0,32'h0,32'h0,32'h0,32'h0,
                0,0,0,14'd0,0,14'd0,32'h0, 1,0,32'h0,32'h0};
    tbl[14] = '{0,0,0,0,4'h0,4'h0,32'h0,32'h0,32'h0,32'h0,
                0,0,0,14'd0,0,14'd0,32'h0, 0,0,32'h0,32'h0};

    // ---------------- reset + directed table ----------------
    rst_n = 1'b0;
    drive(1, 1, 0, 0, 4'h0, 4'h0, 32'h10, 32'h10, 32'h0, 32'h0);
    #1;
    preload(4, 32'hDEADBEEF);
    preload(5, 32'h01020304);
    preload(8, 32'h0);
    @(negedge clk);
    chk("reset_rdy0", {31'b0, p0_req_ready}, 0);
    chk("reset_rdy1", {31'b0, p1_req_ready}, 0);
    chk("reset_rv", {30'b0, p1_resp_valid, p0_resp_valid}, 0);
    chk("reset_sram_en", {30'b0, sram_wen, sram_ren}, 0);
    chk("reset_rdata0", p0_resp_rdata, 0);

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(tbl[i].v0, tbl[i].v1, tbl[i].we0, tbl[i].we1, tbl[i].s0, tbl[i].s1,
            tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("vec%0d_rdy0", i), {31'b0, p0_req_ready}, {31'b0, tbl[i].rdy0});
      chk($sformatf("vec%0d_rdy1", i), {31'b0, p1_req_ready}, {31'b0, tbl[i].rdy1});
      chk($sformatf("vec%0d_ren", i), {31'b0, sram_ren}, {31'b0, tbl[i].ren});
      chk($sformatf("vec%0d_wen", i), {31'b0, sram_wen}, {31'b0, tbl[i].wen});
      if (tbl[i].ren) chk($sformatf("vec%0d_raddr", i), {18'b0, sram_raddr}, {18'b0, tbl[i].raddr});
      if (tbl[i].wen) begin
        chk($sformatf("vec%0d_waddr", i), {18'b0, sram_waddr}, {18'b0, tbl[i].waddr});
        chk($sformatf("vec%0d_wdata", i), sram_wdata, tbl[i].wdata);
      end
      chk($sformatf("vec%0d_rv0", i), {31'b0, p0_resp_valid}, {31'b0, tbl[i].rv0});
      chk($sformatf("vec%0d_rv1", i), {31'b0, p1_resp_valid}, {31'b0, tbl[i].rv1});
      chk($sformatf("vec%0d_rd0", i), p0_resp_rdata, tbl[i].rd0);
      chk($sformatf("vec%0d_rd1", i), p1_resp_rdata, tbl[i].rd1);
    end
    chk("nullwr_mem4", mem[4], 32'hDEADBEEF);
    chk("rmw_mem8", mem[8], 32'h11BB33DD);

    // ---------------- reset during RMW write cycle ----------------
    @(posedge clk); #1;
    drive(1, 0, 1, 0, 4'h3, 4'h0, 32'h20, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstrmw_grant", {31'b0, p0_req_ready}, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1, 1, 0, 0, 4'h0, 4'h0, 32'h20, 32'h20, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstrmw_wen", {31'b0, sram_wen}, 0);
    chk("rstrmw_rdy", {30'b0, p1_req_ready, p0_req_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstrmw_no_ack", {30'b0, p1_resp_valid, p0_resp_valid}, 0);
    chk("rstrmw_p0_wins", {30'b0, p1_req_ready, p0_req_ready}, 2'b01);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstrmw_rv0", {31'b0, p0_resp_valid}, 1);
    chk("rstrmw_rd0", p0_resp_rdata, 32'h11BB33DD);
    chk("rstrmw_mem8", mem[8], 32'h11BB33DD);

    // ---------------- randomized phase against transaction model ----------------
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int w = 0; w < 16; w++) begin
      logic [31:0] v;
      v = $urandom;
      ref_mem[w] = v;
      preload(w, v);
    end
    prefer = 0; busy = 0; pend_v = 0; pend_p = 0; pend_due = 0; pend_d = 0;
    busy_idx = 0; busy_val = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        v0, v1, we0, we1;
      logic [3:0]  s0, s1;
      logic [31:0] a0, a1, d0, d1;
      logic        ev0, ev1, ewen, eren;
      int          win, eidx;
      logic        wwe;
      logic [3:0]  wst;
      logic [31:0] wa, wd, merged;

      @(posedge clk); #1;
      rst_n = 1'b1;
      v0 = (cyc < 596) && ($urandom_range(0, 9) < 7);
      v1 = (cyc < 596) && ($urandom_range(0, 9) < 7);
      we0 = $urandom_range(0, 1) == 1;
      we1 = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3)) 0: s0 = 4'hF; 1: s0 = 4'h0; default: s0 = 4'($urandom); endcase
      case ($urandom_range(0, 3)) 0: s1 = 4'hF; 1: s1 = 4'h0; default: s1 = 4'($urandom); endcase
      a0 = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2);
      a1 = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2);
      d0 = $urandom; d1 = $urandom;
      drive(v0, v1, we0, we1, s0, s1, a0, a1, d0, d1);
      @(negedge clk);

      ev0 = pend_v && (pend_due == cyc) && (pend_p == 0);
      ev1 = pend_v && (pend_due == cyc) && (pend_p == 1);
      chk("rnd_rv0", {31'b0, p0_resp_valid}, {31'b0, ev0});
      chk("rnd_rv1", {31'b0, p1_resp_valid}, {31'b0, ev1});
      chk("rnd_rd0", p0_resp_rdata, ev0 ? pend_d : 32'h0);
      chk("rnd_rd1", p1_resp_rdata, ev1 ? pend_d : 32'h0);
      if (pend_v && pend_due == cyc) pend_v = 0;

      if (busy) begin
        chk("rnd_busy_rdy", {30'b0, p1_req_ready, p0_req_ready}, 0);
        chk("rnd_busy_wen", {31'b0, sram_wen}, 1);
        chk("rnd_busy_ren", {31'b0, sram_ren}, 0);
        chk("rnd_busy_waddr", {18'b0, sram_waddr}, 32'(busy_idx));
        chk("rnd_busy_wdata", sram_wdata, busy_val);
        busy = 0;
      end else begin
        if (v0 && v1) win = prefer;
        else if (v0) win = 0;
        else if (v1) win = 1;
        else win = -1;
        chk("rnd_rdy0", {31'b0, p0_req_ready}, {31'b0, win == 0});
        chk("rnd_rdy1", {31'b0, p1_req_ready}, {31'b0, win == 1});
        ewen = 0; eren = 0; eidx = 0; wd = 0;
        if (win >= 0) begin
          prefer = 1 - win;
          wwe = win ? we1 : we0;
          wst = win ? s1 : s0;
          wa  = win ? a1 : a0;
          wd  = win ? d1 : d0;
          eidx = int'((wa / 4) % (1 << AW));
          pend_v = 1; pend_p = win; pend_d = 0; pend_due = cyc + 1;
          if (!wwe) begin
            eren = 1;
            pend_d = ref_mem[eidx];
          end else if (wst == 4'hF) begin
            ewen = 1;
            ref_mem[eidx] = wd;
          end else if (wst != 4'h0) begin
            eren = 1;
            merged = ref_mem[eidx];
            for (int b = 0; b < 4; b++)
              if (wst[b]) merged[8*b +: 8] = wd[8*b +: 8];
            ref_mem[eidx] = merged;
            busy = 1; busy_idx = eidx; busy_val = merged;
            pend_due = cyc + 2;
          end
        end
        chk("rnd_ren", {31'b0, sram_ren}, {31'b0, eren});
        chk("rnd_wen", {31'b0, sram_wen}, {31'b0, ewen});
        if (eren) chk("rnd_raddr", {18'b0, sram_raddr}, 32'(eidx));
        if (ewen) begin
          chk("rnd_waddr", {18'b0, sram_waddr}, 32'(eidx));
          chk("rnd_wdata", sram_wdata, wd);
        end
      end
    end

    @(posedge clk); #1;
    for (int w = 0; w < 16; w++) begin
      chk($sformatf("rnd_mem%0d", w), mem[w], ref_mem[w]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Shares one 32-bit word SRAM between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- The SRAM has one write port, one read port, 1-cycle registered read data and no byte enables.
- Grants one request per cycle using round-robin arbitration.
- Implements byte-strobed partial writes as read-modify-write (RMW).
- Sits between the core memory interfaces and the SRAM instance.

Parameters:
- DEPTH, 65536, SRAM size in bytes. Word count is DEPTH/4; word address width AW is fixed at 14 for the default.
- ADDR_W, 32, width of the requester byte address.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- pN_req_valid  in  1  request valid, N=0,1
- pN_req_ready  out  1  request accepted this cycle when valid&ready
- pN_req_addr  in  ADDR_W  byte address; word index = addr[AW+1:2], other bits ignored
- pN_req_we  in  1  1 = write, 0 = read
- pN_req_wstrb  in  4  byte enables for writes; bit i covers wdata[8i+7:8i]
- pN_req_wdata  in  32  write data
- pN_resp_valid  out  1  one-cycle response pulse; no backpressure
- pN_resp_rdata  out  32  read data when resp_valid for a read; 0 for a write ack
- sram_wen  out  1  SRAM write enable
- sram_waddr  out  AW  SRAM write word address
- sram_wdata  out  32  SRAM write data
- sram_ren  out  1  SRAM read enable
- sram_raddr  out  AW  SRAM read word address
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_ren

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, rr_ptr=0 (port 0 wins the first conflict).
  - All resp_valid, sram_wen and sram_ren = 0; resp_rdata = 0.
  - An RMW in progress is abandoned: no write issued, no response.
- States: IDLE (accepting), RMW_WR (merge write cycle).
- IDLE arbitration:
  - Candidate = the valid request(s). On conflict, the port selected by rr_ptr wins.
  - After any grant, rr_ptr points to the other port.
  - A single valid request wins regardless of rr_ptr.
  - pN_req_ready = 1 only for the winner. ready may depend combinationally on valid.
  - At most one grant per cycle.
- Read grant (cycle T): sram_ren=1, sram_raddr=word index. pN_resp_valid=1 at T+1 with resp_rdata=sram_rdata.
- Full write grant (we=1, wstrb=4'hF, cycle T): sram_wen=1 with address/data in cycle T. Write ack pN_resp_valid=1 at T+1.
- Write with wstrb=4'h0: treated as a full-throughput no-op. No SRAM access; ack at T+1.
- Partial write grant (any other wstrb, cycle T):
  - In cycle T: sram_ren=1; latch port, word address, wstrb, wdata; go to RMW_WR.
  - RMW_WR (T+1): merge bytewise, taking wdata where the strobe is set and sram_rdata elsewhere. Drive sram_wen=1. Both readys = 0.
  - Return to IDLE. Ack at T+2.
- Throughput and ordering:
  - Reads and full writes are back-to-back: a new grant is allowed in the same cycle as the previous response.
  - Only one transaction is in the SRAM at a time, so responses return in grant order.
  - Read-after-write to the same word in consecutive grants returns the new data.
- resp_valid asserts only on the port that owns the response. Response registers are cleared to 0 when not valid.
- rr_ptr does not change in cycles with no grant or in RMW_WR.
- Port 0 may also issue writes; both ports are symmetric.

Decomposition:
- Shared package:
  - state encoding (ST_IDLE, ST_RMW_WR)
  - AW localparam derivation
  - byte-merge function (strobe, new, old)
- Natural sub-module: sram_rr_arb2, a 2-requester round-robin arbiter with grant one-hot and pointer update. It is reusable by other shared resources.

Test Plan:
- Reset then a p0 read of addr 0x10 pre-loaded with 0xDEADBEEF -> p0_req_ready=1 in T, sram_ren=1 with raddr=4, p0_resp_valid=1 with rdata 0xDEADBEEF at T+1.
- Both ports request reads every cycle for 4 cycles -> grants alternate p0,p1,p0,p1; each resp_valid pulses exactly one cycle after its own grant.
- p1 writes 0x11223344 wstrb=F to 0x20, then p0 reads 0x20 next cycle -> read returns 0x11223344.
- Word 0x20 = 0x11223344; p1 writes 0xAABBCCDD wstrb=4'b0101 -> sram_wen at T+1 with 0x11BB33DD, ack at T+2, both readys 0 at T+1; a following read returns 0x11BB33DD.
- Assert rst_n=0 in the RMW_WR cycle of a partial write -> no sram_wen, no resp_valid, memory word unchanged, next grant goes to p0 on conflict.
- Write with wstrb=0 -> no sram_wen/sram_ren, ack at T+1, memory unchanged.
